// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants for the drawing paths.
// Pure definitions: no latency, no flow control.
package fb_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int FB_WORDS = H_RES * V_RES;
  localparam int ADDR_W   = 15;

  typedef logic [2:0] colour_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    colour_t           colour;
  } pixel_req_t;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } pb_state_t;

  // y*160 as two shifts keeps the multiplier out of the push path.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/plot_buffer_if.sv
// Framebuffer write port: word address, colour, write request held until ready.
// Master owns fb_we/fb_addr/fb_data; slave (memory) owns fb_ready.
interface plot_buffer_if;
  import fb_pkg::*;

  logic [ADDR_W-1:0] fb_addr;
  colour_t           fb_data;
  logic              fb_we;
  logic              fb_ready;

  modport master (output fb_addr, output fb_data, output fb_we, input fb_ready);
  modport slave  (input fb_addr, input fb_data, input fb_we, output fb_ready);
endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers; pop data is the head, read combinationally.
// Push accepted when not full or popping in the same cycle; pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign pop_dat = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/plot_buffer.sv
// Buffers drawer plot strobes into framebuffer writes, filters off-screen pixels, sweeps screen clears.
// Strobe to fb_we is 2 cycles min; fb_ready low holds the output word and fills the FIFO, then drops with overflow.
module plot_buffer import fb_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           vga_x,
  input  logic [6:0]           vga_y,
  input  colour_t              vga_colour,
  input  logic                 vga_plot,
  input  logic                 clear_start,
  input  colour_t              clear_colour,
  plot_buffer_if.master        fb,
  output logic                 idle,
  output logic                 clear_done,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(H_RES * V_RES);

  pb_state_t         state, state_n;
  logic [ADDR_W-1:0] clr_cnt;
  colour_t           clr_colour;
  pixel_req_t        out_word, nxt_word, fifo_head, push_word;
  logic              fb_we_q, nxt_we;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              on_screen, push_req, push_ok;
  logic              load, clr_step, done_n;

  assign on_screen = (vga_x < 8'(H_RES)) && (vga_y < 7'(V_RES));
  assign push_req  = vga_plot && on_screen;
  assign push_ok   = push_req && (!fifo_full || fifo_pop);
  assign push_word = '{addr: xy_to_addr(vga_x, vga_y), colour: vga_colour};
  assign load      = !fb_we_q || fb.fb_ready;

  sync_fifo #(.WIDTH($bits(pixel_req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_dat (push_word),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    nxt_we   = fb_we_q;
    nxt_word = out_word;
    clr_step = 1'b0;
    done_n   = 1'b0;
    case (state)
      RUN: begin
        if (load) begin
          nxt_we   = !fifo_empty;
          fifo_pop = !fifo_empty;
          if (!fifo_empty) nxt_word = fifo_head;
        end
        if (clear_start) state_n = CLEAR;
      end
      CLEAR: begin
        if (load) begin
          nxt_we   = (clr_cnt != WORDS);
          clr_step = (clr_cnt != WORDS);
          if (clr_cnt != WORDS) nxt_word = '{addr: clr_cnt, colour: clr_colour};
        end
        // clr_cnt reaches WORDS only once the last clear word is in the output register
        if ((clr_cnt == WORDS) && fb_we_q && fb.fb_ready) begin
          state_n = RUN;
          done_n  = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we_q    <= 1'b0;
      out_word   <= '0;
      clr_cnt    <= '0;
      clr_colour <= '0;
      clear_done <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      fb_we_q    <= nxt_we;
      out_word   <= nxt_word;
      clear_done <= done_n;
      if (state == RUN && clear_start) begin
        clr_cnt    <= '0;
        clr_colour <= clear_colour;
      end else if (clr_step) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (push_req && !push_ok) overflow <= 1'b1;
      if (vga_plot && !on_screen && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

  assign fb.fb_we   = fb_we_q;
  assign fb.fb_addr = out_word.addr;
  assign fb.fb_data = out_word.colour;
  assign idle       = (state == RUN) && fifo_empty && !fb_we_q;

endmodule
